// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared types, ASCII constants and key mapping for the serial keyboard
package kbd_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam logic [7:0] ASCII_LF       = 8'h0A;
    localparam logic [7:0] ASCII_DEL      = 8'h7F;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_LC_A     = 8'h61;
    localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
    localparam int         KBD_STROBE_BIT = 7;

    // Upper-case letters only and DEL acts as backspace.
    function automatic logic [6:0] map_key(input logic [6:0] c);
        if (c >= ASCII_LC_A[6:0] && c <= ASCII_LC_Z[6:0])
            map_key = c - 7'h20;
        else if (c == ASCII_DEL[6:0])
            map_key = ASCII_BS[6:0];
        else
            map_key = c;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - synchronous typeahead FIFO; a pop frees room for a push in the same cycle
module kbd_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic             i_phi,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_phi) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_phi) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/kbd_uart_rx.sv
// rtl/kbd_uart_rx.sv - 8N1 serial receiver feeding the CPU keyboard data register {strobe, key}
module kbd_uart_rx
    import kbd_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_phi,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_kbd_clr,
    output logic [7:0] o_kbd_dbo,
    output logic       o_overrun,
    output logic       o_framing_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_rx_m;
    logic             r_rx_s;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [CNT_W-1:0] w_clk_cnt_nxt;
    logic [2:0]       r_bit_cnt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_wait_high;
    logic             w_wait_high_nxt;
    logic             w_stop_ok;
    logic             w_stop_bad;

    logic             r_done;
    logic [6:0]       r_char;
    logic             r_framing_err;
    logic             r_overrun;
    logic             r_strobe;
    logic [6:0]       r_key;
    logic             r_clr_q;

    logic             w_push;
    logic             w_pop;
    logic             w_clr_edge;
    logic [6:0]       w_head;
    logic             w_empty;
    logic             w_full;

    always_ff @(posedge i_phi) begin
        if (i_rst) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= i_rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge i_phi) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_clk_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_wait_high   <= 1'b0;
            r_done        <= 1'b0;
            r_char        <= '0;
            r_framing_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_clk_cnt     <= w_clk_cnt_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_wait_high   <= w_wait_high_nxt;
            r_done        <= w_stop_ok;
            r_framing_err <= w_stop_bad;
            if (w_stop_ok)
                r_char <= r_shift[6:0];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_stop_ok       = 1'b0;
        w_stop_bad      = 1'b0;
        // After a bad stop bit the line is still low; wait for idle before hunting a new start.
        w_wait_high_nxt = r_wait_high && !r_rx_s;
        case (r_state)
            IDLE: begin
                if (!r_rx_s && !r_wait_high) begin
                    w_state_nxt   = START;
                    w_clk_cnt_nxt = '0;
                end
            end
            START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = r_rx_s ? IDLE : DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7)
                        w_state_nxt = STOP;
                    else
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_clk_cnt == CNT_LAST) begin
                    w_clk_cnt_nxt = '0;
                    w_state_nxt   = IDLE;
                    if (r_rx_s) begin
                        w_stop_ok = 1'b1;
                    end else begin
                        w_stop_bad      = 1'b1;
                        w_wait_high_nxt = 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_push     = r_done && (r_char != ASCII_LF[6:0]);
    assign w_clr_edge = i_kbd_clr && !r_clr_q;
    assign w_pop      = !w_clr_edge && !r_strobe && !w_empty;

    kbd_fifo #(
        .WIDTH (7),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_phi   (i_phi),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (map_key(r_char)),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Clear wins over load, so a freshly cleared strobe reloads one cycle later.
    always_ff @(posedge i_phi) begin
        if (i_rst) begin
            r_clr_q   <= 1'b0;
            r_strobe  <= 1'b0;
            r_key     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_clr_q <= i_kbd_clr;
            if (w_clr_edge) begin
                r_strobe <= 1'b0;
            end else if (w_pop) begin
                r_strobe <= 1'b1;
                r_key    <= w_head;
            end
            if (w_push && w_full && !w_pop)
                r_overrun <= 1'b1;
        end
    end

    assign o_kbd_dbo[KBD_STROBE_BIT]     = r_strobe;
    assign o_kbd_dbo[KBD_STROBE_BIT-1:0] = r_key;
    assign o_overrun                     = r_overrun;
    assign o_framing_err                 = r_framing_err;

endmodule
